// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshakes, responses and memory bus of the
// shared data-memory arbiter; slave = arbiter side, master = requesters/memory.
interface dmem_arbiter_if #(
    parameter int DW = 32
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_we;
    logic [31:0]   req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid;
    logic          req1_ready;
    logic          req1_we;
    logic [31:0]   req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_rdata;
    logic          rsp0_err;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_rdata;
    logic          rsp1_err;
    logic          mem_rw;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp0_err,
        output rsp1_valid, rsp1_rdata, rsp1_err,
        output mem_rw, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp0_err,
        input  rsp1_valid, rsp1_rdata, rsp1_err,
        input  mem_rw, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two requesters share one data memory, IDLE->ACCESS->RESP.
// Define DMEM_ARB_RR_EN for round-robin tie-break; default is port 0 priority.
module dmem_arbiter #(
    parameter int DEPTH = 64,
    parameter int DW    = 32
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]    state;
    logic          lat_port;
    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    logic idle;
    logic access;
    logic resp;
    logic in_range;
    logic gnt0;
    logic gnt1;

    // Reset masks every output so an aborted store never reaches memory.
    assign idle     = (state == S_IDLE) && !rst;
    assign access   = (state == S_ACCESS) && !rst;
    assign resp     = (state == S_RESP) && !rst;
    assign in_range = lat_addr < 32'(DEPTH);

`ifdef DMEM_ARB_RR_EN
    logic last_gnt;

    assign gnt0 = idle && bus.req0_valid
               && (!bus.req1_valid || last_gnt);
    assign gnt1 = idle && bus.req1_valid
               && (!bus.req0_valid || !last_gnt);

    always_ff @(posedge clk) begin
        if (rst)
            last_gnt <= 1'b1;
        else if (gnt0 || gnt1)
            last_gnt <= gnt1;
    end
`else
    assign gnt0 = idle && bus.req0_valid;
    assign gnt1 = idle && bus.req1_valid && !bus.req0_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            lat_port  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt0 || gnt1) begin
                        state     <= S_ACCESS;
                        lat_port  <= gnt1;
                        lat_we    <= gnt1 ? bus.req1_we : bus.req0_we;
                        lat_addr  <= gnt1 ? bus.req1_addr : bus.req0_addr;
                        lat_wdata <= gnt1 ? bus.req1_wdata : bus.req0_wdata;
                    end
                end
                S_ACCESS: begin
                    state    <= S_RESP;
                    rsp_data <= (!lat_we && in_range) ? bus.mem_rdata : '0;
                    rsp_err  <= !in_range;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    assign bus.rsp0_valid = resp && !lat_port;
    assign bus.rsp1_valid = resp && lat_port;
    assign bus.rsp0_rdata = bus.rsp0_valid ? rsp_data : '0;
    assign bus.rsp1_rdata = bus.rsp1_valid ? rsp_data : '0;
    assign bus.rsp0_err   = bus.rsp0_valid && rsp_err;
    assign bus.rsp1_err   = bus.rsp1_valid && rsp_err;

    assign bus.mem_rw    = !(access && lat_we && in_range);
    assign bus.mem_addr  = access ? lat_addr : '0;
    assign bus.mem_wdata = access ? lat_wdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of grant, latency, range errors, reset
// abort and back-to-back throughput against a behavioural 64-word memory.
module tb_dmem_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   passed;
    int   wr_cnt;
    int   rsp0_cnt;
    int   snap;
    logic [31:0] mem [64];

    dmem_arbiter_if #(.DW(32)) bus ();

    dmem_arbiter #(.DEPTH(64), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = (bus.mem_addr < 32'd64) ? mem[bus.mem_addr[5:0]] : 32'd0;

    always @(posedge clk) begin
        if (!bus.mem_rw) begin
            wr_cnt <= wr_cnt + 1;
            if (bus.mem_addr < 32'd64)
                mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        end
        if (bus.rsp0_valid)
            rsp0_cnt <= rsp0_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.req0_valid = v;
        bus.req0_we    = we;
        bus.req0_addr  = a;
        bus.req0_wdata = d;
    endtask

    task automatic set1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.req1_valid = v;
        bus.req1_we    = we;
        bus.req1_addr  = a;
        bus.req1_wdata = d;
    endtask

    initial begin
        checks   = 0;
        passed   = 0;
        wr_cnt   = 0;
        rsp0_cnt = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        rst = 1'b1;
        set0(1'b0, 1'b0, 32'd0, 32'd0);
        set1(1'b0, 1'b0, 32'd0, 32'd0);

        // reset state, with a request pending that must not be granted
        tick();
        tick();
        set0(1'b1, 1'b0, 32'd5, 32'd0);
        settle();
        chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
        chk("rst_rsp0", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("rst_mem_rw", {31'd0, bus.mem_rw}, 32'd1);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        tick();
        rst = 1'b0;

        // store 17 <- 56 then load 17
        set0(1'b1, 1'b1, 32'd17, 32'd56);
        settle();
        chk("st_ready0", {31'd0, bus.req0_ready}, 32'd1);
        chk("st_ready1", {31'd0, bus.req1_ready}, 32'd0);
        chk("idle_mem_rw", {31'd0, bus.mem_rw}, 32'd1);
        tick();
        set0(1'b0, 1'b0, 32'd0, 32'd0);
        settle();
        chk("st_mem_rw", {31'd0, bus.mem_rw}, 32'd0);
        chk("st_mem_addr", bus.mem_addr, 32'd17);
        chk("st_mem_wdata", bus.mem_wdata, 32'd56);
        chk("st_acc_rsp0", {31'd0, bus.rsp0_valid}, 32'd0);
        tick();
        chk("st_rsp0", {31'd0, bus.rsp0_valid}, 32'd1);
        chk("st_rdata", bus.rsp0_rdata, 32'd0);
        chk("st_err", {31'd0, bus.rsp0_err}, 32'd0);
        chk("st_rsp1", {31'd0, bus.rsp1_valid}, 32'd0);
        chk("st_memval", mem[17], 32'd56);
        chk("st_resp_mem_rw", {31'd0, bus.mem_rw}, 32'd1);
        tick();
        set0(1'b1, 1'b0, 32'd17, 32'd0);
        settle();
        chk("ld_ready0", {31'd0, bus.req0_ready}, 32'd1);
        tick();
        set0(1'b0, 1'b0, 32'd0, 32'd0);
        settle();
        chk("ld_mem_rw", {31'd0, bus.mem_rw}, 32'd1);
        chk("ld_mem_addr", bus.mem_addr, 32'd17);
        tick();
        chk("ld_rsp0", {31'd0, bus.rsp0_valid}, 32'd1);
        chk("ld_rdata", bus.rsp0_rdata, 32'd56);
        chk("ld_err", {31'd0, bus.rsp0_err}, 32'd0);
        tick();

        // port 1 out-of-range store
        snap = wr_cnt;
        set1(1'b1, 1'b1, 32'd64, 32'hAA);
        settle();
        chk("oor_ready1", {31'd0, bus.req1_ready}, 32'd1);
        chk("oor_ready0", {31'd0, bus.req0_ready}, 32'd0);
        tick();
        set1(1'b0, 1'b0, 32'd0, 32'd0);
        settle();
        chk("oor_mem_rw", {31'd0, bus.mem_rw}, 32'd1);
        tick();
        chk("oor_rsp1", {31'd0, bus.rsp1_valid}, 32'd1);
        chk("oor_err", {31'd0, bus.rsp1_err}, 32'd1);
        chk("oor_rdata", bus.rsp1_rdata, 32'd0);
        chk("oor_rsp0", {31'd0, bus.rsp0_valid}, 32'd0);
        tick();
        chk("oor_nowrite", wr_cnt, snap);

        // both ports hold valid from reset: tie-break sequence
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set0(1'b1, 1'b0, 32'd17, 32'd0);
        set1(1'b1, 1'b0, 32'd3, 32'd0);
        for (int c = 0; c < 10; c++) begin
            settle();
            if (c == 0) chk("tie0_ready0", {31'd0, bus.req0_ready}, 32'd1);
            if (c == 2) chk("tie0_rdata", bus.rsp0_rdata, 32'd56);
`ifdef DMEM_ARB_RR_EN
            if (c == 3) chk("tie1_ready1", {31'd0, bus.req1_ready}, 32'd1);
            if (c == 5) chk("tie1_rsp1", {31'd0, bus.rsp1_valid}, 32'd1);
            if (c == 6) chk("tie2_ready0", {31'd0, bus.req0_ready}, 32'd1);
            if (c == 9) chk("tie3_ready1", {31'd0, bus.req1_ready}, 32'd1);
`else
            if (c == 3) chk("tie1_ready0", {31'd0, bus.req0_ready}, 32'd1);
            if (c == 5) chk("tie1_rsp1", {31'd0, bus.rsp1_valid}, 32'd0);
            if (c == 6) chk("tie2_ready0", {31'd0, bus.req0_ready}, 32'd1);
            if (c == 9) chk("tie3_ready1", {31'd0, bus.req1_ready}, 32'd0);
`endif
            tick();
        end
        set0(1'b0, 1'b0, 32'd0, 32'd0);
        set1(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        tick();

        // reset during ACCESS of a store to 15 aborts it
        snap = wr_cnt;
        set0(1'b1, 1'b1, 32'd15, 32'h99);
        settle();
        chk("ab_ready0", {31'd0, bus.req0_ready}, 32'd1);
        tick();
        set0(1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        settle();
        chk("ab_mem_rw", {31'd0, bus.mem_rw}, 32'd1);
        tick();
        rst = 1'b0;
        settle();
        chk("ab_rsp0", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("ab_memval", mem[15], 32'd0);
        chk("ab_nowrite", wr_cnt, snap);
        set0(1'b1, 1'b0, 32'd15, 32'd0);
        settle();
        chk("ab_idle_ready0", {31'd0, bus.req0_ready}, 32'd1);
        set0(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("ab_after_rsp0", {31'd0, bus.rsp0_valid}, 32'd0);

        // back-to-back port 0 loads with valid held high
        snap = rsp0_cnt;
        set0(1'b1, 1'b0, 32'd17, 32'd0);
        for (int c = 0; c < 9; c++) begin
            settle();
            chk("b2b_ready0", {31'd0, bus.req0_ready}, (c % 3 == 0) ? 32'd1 : 32'd0);
            chk("b2b_rsp0", {31'd0, bus.rsp0_valid}, (c % 3 == 2) ? 32'd1 : 32'd0);
            tick();
        end
        set0(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("b2b_rsp_count", rsp0_cnt - snap, 32'd3);
        chk("b2b_idle_rsp0", {31'd0, bus.rsp0_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words in the shared data memory.
REQ-002 SHALL have parameter DW, default 32, data width of requests, responses and memory bus.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  requester 0 (core LSU) / 1 (debug/DMA) request valid.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  request accepted this cycle.
REQ-007 SHALL have ports req0_we/req1_we  input  1  1=store, 0=load.
REQ-008 SHALL have ports req0_addr/req1_addr  input  32  word address.
REQ-009 SHALL have ports req0_wdata/req1_wdata  input  DW  store data.
REQ-010 SHALL have ports rsp0_valid/rsp1_valid  output  1  one-cycle response strobe.
REQ-011 SHALL have ports rsp0_rdata/rsp1_rdata  output  DW  load data; 0 for stores and errors.
REQ-012 SHALL have ports rsp0_err/rsp1_err  output  1  address out of range, valid with rspN_valid.
REQ-013 SHALL have port mem_rw  output  1  memory control, 0=write, 1=read.
REQ-014 SHALL have ports mem_addr  output  32  and mem_wdata  output  DW  memory address and write data.
REQ-015 SHALL have port mem_rdata  input  DW  combinational memory read data.

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction per 3 cycles.
REQ-017 In IDLE, SHALL grant a requester when any reqN_valid=1; reqN_ready SHALL be 1 combinationally for the winner only, only in IDLE.
REQ-018 On grant, SHALL latch port id, we, addr, wdata and go to ACCESS; otherwise stay in IDLE.
REQ-019 When both valid in IDLE, SHALL grant the port not granted last (round-robin, see REQ-030).
REQ-020 In ACCESS, SHALL drive mem_addr/mem_wdata from latched request; mem_rw=0 only if latched we=1 and addr<DEPTH, else 1.
REQ-021 At end of ACCESS, SHALL register mem_rdata into response data for in-range loads, 0 otherwise; SHALL set err=1 when addr>=DEPTH.
REQ-022 In RESP, SHALL assert rspN_valid for the latched port only, for exactly one cycle, with rdata/err; other port's rsp signals 0.
REQ-023 Latency: request accepted in cycle N -> memory written/read in cycle N+1 -> rsp_valid in cycle N+2.
REQ-024 Outside ACCESS, SHALL drive mem_rw=1, mem_addr=0, mem_wdata=0 (never writes).
REQ-025 Requests presented outside IDLE SHALL be held by the requester; no request SHALL be dropped or duplicated.
REQ-026 Out-of-range store SHALL not write memory and SHALL return err=1, rdata=0.

Reset
REQ-027 With rst=1 at a clock edge, SHALL enter IDLE, clear latched request, set last-grant to port 1 (port 0 wins first tie).
REQ-028 During and after reset, all ready/rsp outputs SHALL be 0, mem_rw=1, mem_addr=0, mem_wdata=0.
REQ-029 Reset mid-transaction SHALL abort it: no memory write after the reset edge, no response issued.

Configuration
REQ-030 With macro DMEM_ARB_RR_EN defined, tie-break SHALL be round-robin per REQ-019; without it, port 0 SHALL always win ties (fixed priority) and the last-grant register SHALL be absent.

Verification
REQ-031 Port 0 store addr=17 wdata=56, then load addr=17 -> mem_rw=0 in cycle N+1; load returns rsp0_rdata=56, err=0, at N+2.
REQ-032 Both ports valid every cycle after reset, RR build -> grants 0,1,0,1; fixed build -> grants 0,0,0.
REQ-033 Port 1 store addr=64 -> mem_rw stays 1 all cycles, rsp1_valid=1 with err=1, rdata=0.
REQ-034 rst=1 asserted in ACCESS of a store to addr=15 -> no write, no rsp strobe, FSM in IDLE next cycle.
REQ-035 Back-to-back port 0 loads with valid held high -> req0_ready pulses every 3rd cycle, exactly one rsp0_valid per accepted request.
